shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Controller that sequences an external WIDTH-stage serial shift register (DFF chain on the GoBoard LEDs). It produces a one-cycle shift strobe and the serial input bit, either from a debounced step button (manual mode) or from an internal tick prescaler (auto modes: fill/drain marquee and rotate). It sits between the debouncers and the DFF chain; the DFF chain shifts only when `shift_en` is high.

## Interface
- `WIDTH`, default 4: number of stages in the controlled shift register.
- `TICK_DIV`, default 25_000_000: CLK cycles per auto-mode tick (1 Hz at 25 MHz); legal range ≥ 2.

- `CLK` in 1: system clock; all state is clocked on the rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `btn_mode` in 1: debounced level; each rising edge advances the mode.
- `btn_step` in 1: debounced level; each rising edge requests one manual shift.
- `sw_data` in 1: debounced level; serial bit used in manual mode.
- `q_tap` in 1: output of the last stage of the shift register; used in rotate mode.
- `shift_en` out 1: one-cycle shift strobe to the register chain.
- `shift_din` out 1: serial data for the first stage; valid whenever `shift_en` = 1.
- `mode` out 2: current mode (MANUAL=0, FILL=1, DRAIN=2, ROTATE=3), for LED indication.

## Operation
- Reset: `shift_en`=0, `shift_din`=0, `mode`=MANUAL, prescaler=0, step counter=0, both edge-detect history registers=1. Setting the history to 1 suppresses a spurious edge when a button is held through reset.
- Edge detect: an edge is seen when the input is sampled 1 and its history register holds 0. History updates every cycle.
- `btn_mode` edge:
  - MANUAL→FILL; FILL or DRAIN→ROTATE; ROTATE→MANUAL.
  - Clears the prescaler and the step counter.
  - A mode edge has priority: no shift is issued in that cycle, even if a tick or step edge coincides.
- MANUAL: each `btn_step` edge produces one strobe with `shift_din` = `sw_data` sampled in the edge cycle. No ticks are generated.
- Auto modes (FILL, DRAIN, ROTATE):
  - `btn_step` is ignored.
  - The prescaler counts 0..TICK_DIV-1 and wraps. A tick fires in the cycle the count equals TICK_DIV-1.
  - Each tick produces one strobe.
- FILL: `shift_din`=1 for WIDTH ticks. The step counter counts ticks; at count WIDTH it is cleared and the mode becomes DRAIN.
- DRAIN: `shift_din`=0 for WIDTH ticks, then the mode becomes FILL. This repeats indefinitely.
- ROTATE: tick 1 seeds `shift_din`=1; ticks 2..WIDTH give `shift_din`=0; every later tick gives `shift_din`=`q_tap`. The step counter saturates at WIDTH in ROTATE.
- Step counter width is $clog2(WIDTH+1); it never exceeds WIDTH.

## Timing
- All outputs are registered.
- Manual latency: `btn_step` sampled 1 at edge N (history 0) → `shift_en`=1 during cycle N+1, for exactly one cycle.
- Auto latency: tick at edge N → `shift_en`=1 during cycle N+1.
- Strobe spacing in auto modes is exactly TICK_DIV cycles. The first strobe after a mode change comes TICK_DIV cycles after the mode edge.
- `mode` changes in the cycle after the mode edge. A FILL→DRAIN or DRAIN→FILL transition takes effect in the same cycle as the strobe for the WIDTH-th tick.
- A held button produces exactly one event; a new event requires release for at least one cycle.
- Reset asserted mid-operation: outputs go to reset values immediately (asynchronously), and a strobe in progress is aborted.

## Structure
- Package `shift_seq_pkg`: 2-bit mode typedef and constants MODE_MANUAL, MODE_FILL, MODE_DRAIN, MODE_ROTATE.
- Sub-module `tick_gen` (parameter TICK_DIV; ports CLK, RST_N, `clr`, `tick`): prescaler that produces a one-cycle `tick`. `clr` forces the count to 0, and `tick` is held low while `clr` is high.
- Top level: edge detectors, mode FSM, step counter, output registers.

## Test plan
All scenarios use WIDTH=4, TICK_DIV=5.
- Reset with `btn_step`=1 held: release `RST_N`, hold 10 cycles → no `shift_en`; `mode`=0.
- MANUAL: `sw_data`=1, then pulse `btn_step` for 3 cycles → exactly one `shift_en`, one cycle after the edge, with `shift_din`=1. Repeat with `sw_data`=0 → `shift_din`=0.
- FILL/DRAIN: one `btn_mode` edge → strobes every 5 cycles with `shift_din` sequence 1,1,1,1,0,0,0,0,1. `mode` goes 1→2 at strobe 4 and 2→1 at strobe 8.
- ROTATE: two mode edges, `q_tap` driven by a 4-stage DFF model → `shift_din` = 1,0,0,0 then follows `q_tap`. The model's contents cycle 0001→0010→0100→1000→0001.
- Collision: `btn_mode` edge in the same cycle as a tick → no strobe; new mode; next strobe 5 cycles later.
- Mid-operation reset: pull `RST_N` low 2 cycles after a tick during FILL → `shift_en`=0 and `mode`=0 asynchronously; no strobe for 10 cycles after release.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - mode encoding shared by the shift sequencer
package shift_seq_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_FILL   = 2'd1,
    MODE_DRAIN  = 2'd2,
    MODE_ROTATE = 2'd3
  } mode_t;

  // Mode button order: MANUAL -> FILL -> ROTATE -> MANUAL; DRAIN also jumps to ROTATE.
  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_MANUAL:            return MODE_FILL;
      MODE_FILL, MODE_DRAIN:  return MODE_ROTATE;
      default:                return MODE_MANUAL;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running prescaler emitting a one-cycle tick every TICK_DIV clocks
module tick_gen #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             at_last;

  assign at_last = (cnt == CNT_LAST);
  assign tick    = at_last & ~clr;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (clr || at_last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - drives shift strobe and serial bit for an external DFF chain
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int TICK_DIV = 25_000_000
) (
  input  logic  CLK,
  input  logic  RST_N,
  input  logic  btn_mode,
  input  logic  btn_step,
  input  logic  sw_data,
  input  logic  q_tap,
  output logic  shift_en,
  output logic  shift_din,
  output mode_t mode
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  logic          mode_hist, step_hist;
  logic          mode_edge, step_edge;
  logic          tick, clr;
  logic [CW-1:0] step_cnt, cnt_n;
  mode_t         mode_n;
  logic          en_n, din_n;

  assign mode_edge = btn_mode & ~mode_hist;
  assign step_edge = btn_step & ~step_hist;
  // Prescaler idles at zero in MANUAL so every auto mode starts a full period after its edge.
  assign clr       = mode_edge | (mode == MODE_MANUAL);

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clr   (clr),
    .tick  (tick)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_hist <= 1'b1;
      step_hist <= 1'b1;
      mode      <= MODE_MANUAL;
      step_cnt  <= '0;
      shift_en  <= 1'b0;
      shift_din <= 1'b0;
    end else begin
      mode_hist <= btn_mode;
      step_hist <= btn_step;
      mode      <= mode_n;
      step_cnt  <= cnt_n;
      shift_en  <= en_n;
      shift_din <= din_n;
    end
  end

  always_comb begin
    mode_n = mode;
    cnt_n  = step_cnt;
    en_n   = 1'b0;
    din_n  = shift_din;
    if (mode_edge) begin
      mode_n = next_mode(mode);
      cnt_n  = '0;
    end else begin
      case (mode)
        MODE_MANUAL: begin
          if (step_edge) begin
            en_n  = 1'b1;
            din_n = sw_data;
          end
        end
        MODE_FILL, MODE_DRAIN: begin
          if (tick) begin
            en_n  = 1'b1;
            din_n = (mode == MODE_FILL);
            if (step_cnt == LAST - CW'(1)) begin
              cnt_n  = '0;
              mode_n = (mode == MODE_FILL) ? MODE_DRAIN : MODE_FILL;
            end else begin
              cnt_n = step_cnt + CW'(1);
            end
          end
        end
        default: begin
          if (tick) begin
            en_n = 1'b1;
            // One seed bit, WIDTH-1 zeros, then recirculate the last stage.
            if (step_cnt == '0) begin
              din_n = 1'b1;
            end else if (step_cnt != LAST) begin
              din_n = 1'b0;
            end else begin
              din_n = q_tap;
            end
            if (step_cnt != LAST) begin
              cnt_n = step_cnt + CW'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - scoreboard bench for shift_sequencer (WIDTH=4, TICK_DIV=5)
module tb_shift_sequencer;
  import shift_seq_pkg::*;

  localparam int WIDTH    = 4;
  localparam int TICK_DIV = 5;

  localparam logic [8:0] FD_DIN  = 9'b1_0000_1111;
  localparam int         FD_MODE [9] = '{1, 1, 1, 2, 2, 2, 2, 1, 1};
  localparam logic [7:0] ROT_DIN = 8'b0001_0001;

  logic  CLK = 1'b0;
  logic  RST_N = 1'b0;
  logic  btn_mode = 1'b0;
  logic  btn_step = 1'b0;
  logic  sw_data = 1'b0;
  logic  q_tap;
  logic  shift_en;
  logic  shift_din;
  mode_t mode;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] cyc;
    logic        din;
    logic [1:0]  mode;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [WIDTH-1:0] sr;

  shift_sequencer #(.WIDTH(WIDTH), .TICK_DIV(TICK_DIV)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .btn_mode  (btn_mode),
    .btn_step  (btn_step),
    .sw_data   (sw_data),
    .q_tap     (q_tap),
    .shift_en  (shift_en),
    .shift_din (shift_din),
    .mode      (mode)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // External DFF chain model
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) sr <= '0;
    else if (shift_en) sr <= {sr[WIDTH-2:0], shift_din};
  end
  assign q_tap = sr[WIDTH-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic expect_strobe(input int c, input logic d, input int m);
    exp_t e;
    e.cyc  = c;
    e.din  = d;
    e.mode = m[1:0];
    sb.push_back(e);
  endtask

  always @(negedge CLK) begin
    if (RST_N && shift_en === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe: shift_en=1 at cycle %0d, expected no strobe", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("strobe_cycle", cyc, mon_e.cyc);
        check("strobe_din", {31'd0, shift_din}, {31'd0, mon_e.din});
        check("strobe_mode", {30'd0, mode}, {30'd0, mon_e.mode});
      end
    end
  end

  initial begin
    int p, q, r, s, t, u;

    btn_step = 1'b1;
    step(3);
    check("reset_shift_en", {31'd0, shift_en}, 0);
    check("reset_shift_din", {31'd0, shift_din}, 0);
    check("reset_mode", {30'd0, mode}, 0);
    RST_N = 1'b1;
    step(10);
    check("held_step_mode", {30'd0, mode}, 0);
    btn_step = 1'b0;
    step(2);

    sw_data = 1'b1;
    btn_step = 1'b1;
    expect_strobe(cyc + 1, 1'b1, 0);
    step(3);
    btn_step = 1'b0;
    step(4);
    sw_data = 1'b0;
    btn_step = 1'b1;
    expect_strobe(cyc + 1, 1'b0, 0);
    step(3);
    btn_step = 1'b0;
    step(4);

    p = cyc;
    btn_mode = 1'b1;
    for (int k = 0; k < 9; k++) expect_strobe(p + 6 + 5 * k, FD_DIN[k], FD_MODE[k]);
    step();
    btn_mode = 1'b0;
    check("mode_after_edge", {30'd0, mode}, 1);

    wait_to(p + 47);
    q = cyc;
    btn_mode = 1'b1;
    for (int k = 0; k < 8; k++) expect_strobe(q + 6 + 5 * k, ROT_DIN[k], 3);
    step();
    btn_mode = 1'b0;

    wait_to(q + 42);
    r = cyc;
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    check("rotate_to_manual", {30'd0, mode}, 0);

    s = r + 3;
    wait_to(s);
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    wait_to(s + 5);
    btn_mode = 1'b1;
    expect_strobe(s + 11, 1'b1, 3);
    step();
    btn_mode = 1'b0;
    check("collision_mode", {30'd0, mode}, 3);

    wait_to(s + 12);
    t = cyc;
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    step();
    check("back_to_manual", {30'd0, mode}, 0);

    wait_to(t + 3);
    u = cyc;
    btn_mode = 1'b1;
    expect_strobe(u + 6, 1'b1, 1);
    step();
    btn_mode = 1'b0;
    wait_to(u + 8);
    check("fill_before_reset", {30'd0, mode}, 1);
    RST_N = 1'b0;
    #1;
    check("async_reset_mode", {30'd0, mode}, 0);
    check("async_reset_shift_en", {31'd0, shift_en}, 0);
    step(2);
    RST_N = 1'b1;
    step(12);
    check("post_reset_mode", {30'd0, mode}, 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
